// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Fetch-stage branch target buffer with 2-bit saturating direction counters.
// A direct-mapped table is looked up combinationally with the fetch PC to
// produce a predicted next PC. The decode-stage resolution trains the table
// on the clock edge and flags a mispredict when the resolved next PC differs
// from the prediction that travelled down the pipeline with the instruction.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_if_pc          PC being fetched
//   o_pred_taken     redirect fetch to o_pred_target
//   o_pred_target    stored target of the hit entry, 0 on miss
//   o_pred_pc_nxt    predicted next fetch PC
//   i_id_valid       decode slot holds a real instruction
//   i_id_pc          PC of the decode instruction
//   i_id_is_bj       decode instruction is B, JAL or JALR
//   i_id_is_cond     decode instruction is B (qualified by i_id_is_bj)
//   i_id_taken       resolved redirect
//   i_id_target      resolved target
//   i_id_pred_pc_nxt prediction carried from fetch for this instruction
//   o_mispredict     flush fetch and load o_redirect_pc
//   o_redirect_pc    correct next PC
//   o_bj_count       resolved branches/jumps (saturating)
//   o_miss_count     mispredictions (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 32,
   parameter int XLEN    = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_if_pc,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_target,
   output logic [XLEN-1:0] o_pred_pc_nxt,
   input  logic            i_id_valid,
   input  logic [XLEN-1:0] i_id_pc,
   input  logic            i_id_is_bj,
   input  logic            i_id_is_cond,
   input  logic            i_id_taken,
   input  logic [XLEN-1:0] i_id_target,
   input  logic [XLEN-1:0] i_id_pred_pc_nxt,
   output logic            o_mispredict,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic [31:0]     o_bj_count,
   output logic [31:0]     o_miss_count
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = XLEN - IDX - 2;

   // Saturating increment of a 2-bit direction counter.
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'd3) ? 2'd3 : c + 2'd1;
   endfunction

   // Saturating decrement of a 2-bit direction counter.
   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'd0) ? 2'd0 : c - 2'd1;
   endfunction

   // Saturating increment of a 32-bit event counter.
   function automatic logic [31:0] cnt_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   logic [ENTRIES-1:0] r_valid;
   logic [TAGW-1:0]    r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];
   logic [31:0]        r_bj_count;
   logic [31:0]        r_miss_count;

   logic [IDX-1:0]     w_if_idx;
   logic [TAGW-1:0]    w_if_tag;
   logic               w_if_hit;
   logic [IDX-1:0]     w_id_idx;
   logic [TAGW-1:0]    w_id_tag;
   logic               w_id_hit;
   logic [XLEN-1:0]    w_actual;
   logic               w_mispredict;

   logic               w_wr_en;
   logic               w_wr_valid;
   logic [TAGW-1:0]    w_wr_tag;
   logic [XLEN-1:0]    w_wr_target;
   logic [1:0]         w_wr_ctr;

   assign w_if_idx = i_if_pc[IDX+1:2];
   assign w_if_tag = i_if_pc[XLEN-1:IDX+2];
   assign w_id_idx = i_id_pc[IDX+1:2];
   assign w_id_tag = i_id_pc[XLEN-1:IDX+2];
   assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

   // Fetch-side prediction from the pre-update table contents.
   always_comb begin
      o_pred_taken  = 1'b0;
      o_pred_target = {XLEN{1'b0}};
      if (w_if_hit) begin
         o_pred_taken  = r_ctr[w_if_idx][1];
         o_pred_target = r_target[w_if_idx];
      end else begin
         o_pred_taken  = 1'b0;
         o_pred_target = {XLEN{1'b0}};
      end
      o_pred_pc_nxt = o_pred_taken ? o_pred_target : i_if_pc + XLEN'(4);
   end

   // Decode-side resolution: the true next PC and whether fetch went wrong.
   always_comb begin
      w_actual     = i_id_taken ? i_id_target : i_id_pc + XLEN'(4);
      w_mispredict = i_id_valid && (w_actual != i_id_pred_pc_nxt);
   end

   assign o_mispredict  = w_mispredict;
   assign o_redirect_pc = w_actual;
   assign o_bj_count    = r_bj_count;
   assign o_miss_count  = r_miss_count;

   // Next contents of the entry addressed by the decode PC.
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_valid  = r_valid[w_id_idx];
      w_wr_tag    = r_tag[w_id_idx];
      w_wr_target = r_target[w_id_idx];
      w_wr_ctr    = r_ctr[w_id_idx];
      if (i_id_valid && i_id_is_bj) begin
         if (w_id_hit) begin
            w_wr_en = 1'b1;
            if (i_id_is_cond) begin
               if (i_id_taken) begin
                  w_wr_ctr    = ctr_inc(r_ctr[w_id_idx]);
                  w_wr_target = i_id_target;
               end else begin
                  w_wr_ctr    = ctr_dec(r_ctr[w_id_idx]);
               end
            end else begin
               w_wr_ctr    = 2'd3;
               w_wr_target = i_id_target;
            end
         end else if (i_id_taken) begin
            // Allocation overwrites whatever alias occupied the slot.
            w_wr_en     = 1'b1;
            w_wr_valid  = 1'b1;
            w_wr_tag    = w_id_tag;
            w_wr_target = i_id_target;
            w_wr_ctr    = i_id_is_cond ? 2'd2 : 2'd3;
         end else begin
            w_wr_en = 1'b0;
         end
      end else if (i_id_valid && w_id_hit) begin
         // A non-branch hit means the entry describes code that is gone.
         w_wr_en    = 1'b1;
         w_wr_valid = 1'b0;
      end else begin
         w_wr_en = 1'b0;
      end
   end

   // Table storage: cleared on reset, single-entry write per cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= {TAGW{1'b0}};
            r_target[i] <= {XLEN{1'b0}};
            r_ctr[i]    <= 2'b01;
         end
      end else if (w_wr_en) begin
         r_valid[w_id_idx]  <= w_wr_valid;
         r_tag[w_id_idx]    <= w_wr_tag;
         r_target[w_id_idx] <= w_wr_target;
         r_ctr[w_id_idx]    <= w_wr_ctr;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bj_count   <= 32'd0;
         r_miss_count <= 32'd0;
      end else begin
         if (i_id_valid && i_id_is_bj) begin
            r_bj_count <= cnt_inc(r_bj_count);
         end else begin
            r_bj_count <= r_bj_count;
         end
         if (w_mispredict) begin
            r_miss_count <= cnt_inc(r_miss_count);
         end else begin
            r_miss_count <= r_miss_count;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed sequences for the multi-cycle corner cases, a table of resolution
// vectors, and randomized traffic checked against a behavioural BTB model.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
   localparam int ENTRIES = 32;
   localparam int XLEN    = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] pred_pc_nxt;
   logic        id_valid;
   logic [31:0] id_pc;
   logic        id_is_bj;
   logic        id_is_cond;
   logic        id_taken;
   logic [31:0] id_target;
   logic [31:0] id_pred;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] bj_count;
   logic [31:0] miss_count;

   int n_cmp = 0;
   int n_err = 0;

   branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
      .o_pred_taken(pred_taken), .o_pred_target(pred_target),
      .o_pred_pc_nxt(pred_pc_nxt), .i_id_valid(id_valid), .i_id_pc(id_pc),
      .i_id_is_bj(id_is_bj), .i_id_is_cond(id_is_cond), .i_id_taken(id_taken),
      .i_id_target(id_target), .i_id_pred_pc_nxt(id_pred),
      .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
      .o_bj_count(bj_count), .o_miss_count(miss_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: entries remember their full PC -------
   bit          m_v   [ENTRIES];
   logic [31:0] m_pc  [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];
   int          m_ctr [ENTRIES];
   logic [31:0] m_bj, m_miss;

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_v[m_idx(pc)] && (m_pc[m_idx(pc)] == (pc & ~32'h3));
   endfunction

   function automatic logic [31:0] m_pnxt(input logic [31:0] pc);
      if (m_hit(pc) && m_ctr[m_idx(pc)] >= 2) return m_tgt[m_idx(pc)];
      return pc + 32'd4;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i] = 1'b0; m_pc[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
      end
      m_bj = 32'd0; m_miss = 32'd0;
   endtask

   task automatic m_check();
      logic [31:0] act_nxt;
      bit h;
      int i;
      h = m_hit(if_pc); i = m_idx(if_pc);
      act_nxt = id_taken ? id_target : id_pc + 32'd4;
      chk("rnd_pred_taken", {31'd0, pred_taken}, {31'd0, h && m_ctr[i] >= 2});
      chk("rnd_pred_target", pred_target, h ? m_tgt[i] : 32'd0);
      chk("rnd_pred_pc_nxt", pred_pc_nxt, m_pnxt(if_pc));
      chk("rnd_mispredict", {31'd0, mispredict}, {31'd0, id_valid && act_nxt != id_pred});
      chk("rnd_redirect", redirect_pc, act_nxt);
      chk("rnd_bj_count", bj_count, m_bj);
      chk("rnd_miss_count", miss_count, m_miss);
   endtask

   task automatic m_step();
      logic [31:0] act_nxt;
      bit h;
      int i;
      act_nxt = id_taken ? id_target : id_pc + 32'd4;
      h = m_hit(id_pc); i = m_idx(id_pc);
      if (id_valid) begin
         if (act_nxt != id_pred && m_miss != 32'hFFFF_FFFF) m_miss++;
         if (id_is_bj) begin
            if (m_bj != 32'hFFFF_FFFF) m_bj++;
            if (h) begin
               if (id_is_cond) begin
                  if (id_taken) begin
                     m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                     m_tgt[i] = id_target;
                  end else begin
                     m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                  end
               end else begin
                  m_ctr[i] = 3; m_tgt[i] = id_target;
               end
            end else if (id_taken) begin
               m_v[i] = 1'b1; m_pc[i] = id_pc & ~32'h3; m_tgt[i] = id_target;
               m_ctr[i] = id_is_cond ? 2 : 3;
            end
         end else if (h) begin
            m_v[i] = 1'b0;
         end
      end
   endtask

   // ---------------- helpers -------------------------------------------------
   task automatic idle();
      id_valid = 1'b0; id_pc = 32'd0; id_is_bj = 1'b0; id_is_cond = 1'b0;
      id_taken = 1'b0; id_target = 32'd0; id_pred = 32'd4;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic bj, input logic cond,
                          input logic tk, input logic [31:0] tgt, input logic [31:0] pred);
      id_valid = 1'b1; id_pc = pc; id_is_bj = bj; id_is_cond = cond;
      id_taken = tk; id_target = tgt; id_pred = pred;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; idle(); if_pc = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
   endtask

   typedef struct {
      logic [31:0] if_pc;
      logic        id_valid;
      logic [31:0] id_pc;
      logic        id_taken;
      logic [31:0] id_target;
      logic [31:0] id_pred;
      logic [31:0] exp_pnxt;
      logic        exp_misp;
      logic [31:0] exp_redir;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0104, 32'h0000_0104, 1'b0, 32'h0000_0104};
      vecs[1] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
      vecs[2] = '{32'h0000_0000, 1'b1, 32'h0000_0010, 1'b1, 32'h80, 32'h0000_0014, 32'h0000_0004, 1'b1, 32'h0000_0080};
      vecs[3] = '{32'h0000_1234, 1'b0, 32'h0000_0010, 1'b1, 32'h80, 32'h0000_0014, 32'h0000_1238, 1'b0, 32'h0000_0080};
      vecs[4] = '{32'h8000_0000, 1'b1, 32'h0000_0040, 1'b1, 32'h44, 32'h0000_0044, 32'h8000_0004, 1'b0, 32'h0000_0044};
      vecs[5] = '{32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h8000_0000, 1'b1, 32'h0000_0000};

      rst_n = 1'b0; if_pc = 32'd0; idle();
      do_reset();

      // Reset state and a non-branch that was fetched correctly.
      if_pc = 32'h100; resolve(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h104);
      #1;
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'd0);
      chk("rst_pred_pc_nxt", pred_pc_nxt, 32'h104);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      @(negedge clk);
      chk("rst_bj_count", bj_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);

      // Cold taken branch allocates with counter 2.
      resolve(32'h200, 1'b1, 1'b1, 1'b1, 32'h180, 32'h204);
      #1;
      chk("cold_mispredict", {31'd0, mispredict}, 32'd1);
      chk("cold_redirect", redirect_pc, 32'h180);
      @(negedge clk);
      idle(); if_pc = 32'h200;
      #1;
      chk("cold_miss_count", miss_count, 32'd1);
      chk("cold_bj_count", bj_count, 32'd1);
      chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_pred_target", pred_target, 32'h180);

      // Two not-taken resolutions: 2 -> 1 -> 0.
      @(negedge clk);
      resolve(32'h200, 1'b1, 1'b1, 1'b0, 32'h180, 32'h180);
      #1;
      chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
      chk("nt1_redirect", redirect_pc, 32'h204);
      @(negedge clk);
      idle();
      #1;
      chk("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("nt1_pred_pc_nxt", pred_pc_nxt, 32'h204);
      chk("nt1_hit_target", pred_target, 32'h180);
      @(negedge clk);
      resolve(32'h200, 1'b1, 1'b1, 1'b0, 32'h180, 32'h204);
      #1;
      chk("nt2_mispredict", {31'd0, mispredict}, 32'd0);
      @(negedge clk);
      // One taken from the floor must land on 1, still predicting not-taken.
      resolve(32'h200, 1'b1, 1'b1, 1'b1, 32'h180, 32'h204);
      @(negedge clk);
      idle();
      #1;
      chk("sat0_pred_taken", {31'd0, pred_taken}, 32'd0);
      @(negedge clk);
      resolve(32'h200, 1'b1, 1'b1, 1'b1, 32'h180, 32'h204);
      @(negedge clk);
      idle();
      #1;
      chk("ctr2_pred_taken", {31'd0, pred_taken}, 32'd1);

      // Same-cycle train and lookup: old prediction now, new one next cycle.
      @(negedge clk);
      resolve(32'h200, 1'b1, 1'b1, 1'b0, 32'h180, 32'h180);
      #1;
      chk("same_old_pred", {31'd0, pred_taken}, 32'd1);
      @(negedge clk);
      idle();
      #1;
      chk("same_new_pred", {31'd0, pred_taken}, 32'd0);

      // Non-branch hit scrubs the entry.
      @(negedge clk);
      resolve(32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h204);
      @(negedge clk);
      idle();
      #1;
      chk("scrub_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("scrub_pred_target", pred_target, 32'd0);

      // JAL allocates with counter 3; alias with another tag misses.
      @(negedge clk);
      resolve(32'h300, 1'b1, 1'b0, 1'b1, 32'h40, 32'h304);
      @(negedge clk);
      idle(); if_pc = 32'h300;
      #1;
      chk("jal_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("jal_pred_pc_nxt", pred_pc_nxt, 32'h40);
      @(negedge clk);
      if_pc = 32'h300 + 32'(4 * ENTRIES);
      #1;
      chk("alias_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("alias_pred_pc_nxt", pred_pc_nxt, 32'h384);

      // Miss counter saturation.
      @(negedge clk);
      force dut.r_miss_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_miss_count;
      resolve(32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("sat_mispredict", {31'd0, mispredict}, 32'd1);
      @(negedge clk);
      idle();
      #1;
      chk("sat_miss_count", miss_count, 32'hFFFF_FFFF);

      // Asynchronous reset mid-cycle clears state before the next edge.
      @(negedge clk);
      if_pc = 32'h300;
      #1;
      chk("prerst_pred_taken", {31'd0, pred_taken}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("async_pred_pc_nxt", pred_pc_nxt, 32'h304);
      chk("async_bj_count", bj_count, 32'd0);
      chk("async_miss_count", miss_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();

      // Resolution vector table on an empty table.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if_pc = vecs[k].if_pc;
         resolve(vecs[k].id_pc, 1'b0, 1'b0, vecs[k].id_taken, vecs[k].id_target, vecs[k].id_pred);
         id_valid = vecs[k].id_valid;
         #1;
         chk($sformatf("vec%0d_pred_pc_nxt", k), pred_pc_nxt, vecs[k].exp_pnxt);
         chk($sformatf("vec%0d_pred_taken", k), {31'd0, pred_taken}, 32'd0);
         chk($sformatf("vec%0d_mispredict", k), {31'd0, mispredict}, {31'd0, vecs[k].exp_misp});
         chk($sformatf("vec%0d_redirect", k), redirect_pc, vecs[k].exp_redir);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [31:0] p;
         @(negedge clk);
         if_pc = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 7)) << 2);
         p     = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 7)) << 2);
         id_valid   = ($urandom_range(0, 9) != 0);
         id_pc      = p;
         id_is_bj   = ($urandom_range(0, 4) != 0);
         id_is_cond = $urandom_range(0, 1) == 1;
         id_taken   = (!id_is_cond && id_is_bj) ? 1'b1 : ($urandom_range(0, 1) == 1);
         id_target  = 32'($urandom_range(0, 63)) << 2;
         case ($urandom_range(0, 3))
            0:       id_pred = $urandom;
            1:       id_pred = id_taken ? id_target : p + 32'd4;
            default: id_pred = m_pnxt(p);
         endcase
         #1;
         m_check();
         m_step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch target buffer with 2-bit saturating direction counters. Supplies a predicted next PC for the instruction being fetched. Consumes the decode-stage branch/jump resolution (actual taken flag and target) to train itself, and raises a mispredict/redirect when the resolved next PC differs from the prediction carried down the pipeline. Sits between the PC register/fetch mux and the decode-stage branch resolution logic.

## Interface
- `ENTRIES`, 32: BTB entries; power of two, ≥ 2. `IDX = log2(ENTRIES)`.
- `XLEN`, 32: address width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_pc`  in  XLEN  PC of the instruction being fetched.
- `pred_taken`  out  1  prediction: redirect fetch to `pred_target`.
- `pred_target`  out  XLEN  stored target of the hit entry; 0 on miss.
- `pred_pc_nxt`  out  XLEN  `pred_taken ? pred_target : if_pc + 4`.
- `id_valid`  in  1  decode instruction is real (not bubble/flushed/stalled).
- `id_pc`  in  XLEN  PC of the decode instruction.
- `id_is_bj`  in  1  decode opcode is B, JAL or JALR.
- `id_is_cond`  in  1  decode opcode is B; only meaningful with `id_is_bj`.
- `id_taken`  in  1  resolved redirect (branch taken, or JAL/JALR).
- `id_target`  in  XLEN  resolved branch/jump target.
- `id_pred_pc_nxt`  in  XLEN  `pred_pc_nxt` of this instruction, carried IF→ID.
- `mispredict`  out  1  flush IF and load `redirect_pc` this cycle.
- `redirect_pc`  out  XLEN  correct next PC.
- `bj_count`  out  32  resolved branches/jumps.
- `miss_count`  out  32  mispredictions.

## Operation
- Index `if_pc[IDX+1:2]`; tag `if_pc[XLEN-1:IDX+2]`. Each entry holds valid, tag, target, and a 2-bit counter.
- Lookup is combinational. Hit = valid && tag match. `pred_taken = hit && ctr[1]`.
- Resolution is combinational: `actual = id_taken ? id_target : id_pc + 4`. `mispredict = id_valid && (actual != id_pred_pc_nxt)`. `redirect_pc = actual` always (don't-care when `mispredict` = 0).
- Training happens on the rising edge when `id_valid && id_is_bj`. Entry is indexed/tagged by `id_pc`:
  - Hit, conditional: counter +1 if taken, −1 if not; saturates at 3 and 0. Target is written only if taken.
  - Hit, JAL/JALR: counter ← 3, target ← `id_target`.
  - Miss, taken: allocate, overwriting the slot. valid ← 1, tag, target; counter ← 2 for conditional, 3 for JAL/JALR.
  - Miss, not taken: no change.
- Stale-entry scrub: `id_valid && !id_is_bj` with a hit on `id_pc` clears that entry's valid bit.
- Counters:
  - `bj_count` increments when `id_valid && id_is_bj`.
  - `miss_count` increments when `mispredict`.
  - Both saturate at 0xFFFF_FFFF.
- Arithmetic: `+4` is modulo 2^XLEN. 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - All valid bits = 0, counters = 01, targets/tags = 0.
  - `bj_count` = `miss_count` = 0.
  - Outputs then: `pred_taken` = 0, `pred_target` = 0, `pred_pc_nxt` = `if_pc+4`, `mispredict` = 0 while `id_valid` = 0.
- Lookup latency 0 (same cycle as `if_pc`). Update is visible to lookups the cycle after the training edge.
- Same-cycle update and lookup of the same index: lookup returns pre-update contents.
- `id_valid` = 0: no training, no scrub, no count, `mispredict` = 0, regardless of other ID inputs.
- Stall handling is external: the caller holds `id_valid` low or de-duplicates, so each instruction trains exactly once.
- Reset asserted mid-operation: the table clears immediately; an in-flight `id_pred_pc_nxt` is not trusted (pipeline flushes on reset).

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_pc_nxt`=0x104. `id_valid`=1, non-bj, `id_pred_pc_nxt`=`id_pc`+4 → `mispredict`=0, counts stay 0.
- Cold branch at 0x200 taken to 0x180, predicted 0x204 → `mispredict`=1, `redirect_pc`=0x180, `miss_count`=1. Next cycle `if_pc`=0x200 → `pred_taken`=1, `pred_target`=0x180.
- Branch at 0x200 resolved not-taken twice → counter 2→1→0. `pred_taken` = 0 after the first update; the second update saturates at 0.
- JAL at 0x300 to 0x40 trained once → counter 3, `pred_pc_nxt`=0x40. Aliased PC 0x300+4·ENTRIES fetched → miss, `pred_taken`=0.
- Entry hit by a non-bj at `id_pc` 0x200 → entry invalidated; next lookup at 0x200 gives `pred_taken`=0.
- Same-cycle train and lookup of 0x200 → old prediction that cycle, new one the next. Force `miss_count`=0xFFFFFFFF, then mispredict → stays saturated. Async `rst_n` low mid-run → all state cleared within the same cycle.
